regfile_sequencer: RTL
======================

# regfile_sequencer

Single-issue execute/writeback sequencer that drives the 8-entry × 8-bit register file of the RISC FSM core: it accepts one 16-bit instruction at a time over a valid/ready handshake, issues the register-file read addresses, latches operands, executes them in an internal 8-bit ALU and issues the write-back (ALU result or immediate). It sits between the fetch/decode front end and the register file, and owns every register-file control signal.

## Interface
- No parameters: data width 8, register address width 3, instruction width 16.
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- instr  in  16  instruction: [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, [7:0] imm (LDI only)
- instr_valid  in  1  instr is presented
- instr_ready  out  1  block can accept; high only in IDLE and not in reset
- rf_rd_addr1  out  3  register-file read address 1 (rs1)
- rf_rd_addr2  out  3  register-file read address 2 (rs2)
- rf_rd_data1  in  8  combinational read data for rf_rd_addr1
- rf_rd_data2  in  8  combinational read data for rf_rd_addr2
- rf_we  out  1  register-file write enable
- rf_wr_addr  out  3  write address (rd)
- rf_wr_data_alu  out  8  ALU result register
- rf_wr_data_imm  out  8  latched immediate
- rf_wr_sel  out  1  1 = write immediate, 0 = write ALU result
- done  out  1  one-cycle pulse when an instruction retires
- illegal  out  1  one-cycle pulse, coincident with done, for an unknown opcode
- flag_z  out  1  zero flag
- flag_c  out  1  carry/borrow flag

## Operation
- Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 LDI, 7 MOV (rd = rs1), 8–15 illegal (executed as NOP).
- States: IDLE, READ, EXEC, WB.
- IDLE: instr_ready=1; on instr_valid, latch instr. Next state: ALU ops/MOV → READ; LDI, NOP, illegal → WB.
- READ: rf_rd_addr1/2 = latched rs1/rs2; capture rf_rd_data1/2 into operand registers at end of cycle → EXEC.
- EXEC: compute result into rf_wr_data_alu; update flags → WB.
- WB: rf_we=1 for ALU ops, MOV and LDI; rf_we=0 for NOP/illegal. done=1; illegal=1 if opcode ≥ 8 → IDLE.
- Arithmetic: ADD is the 9-bit sum, result = [7:0], C = bit 8. SUB result = (rs1 − rs2) mod 256, C = 1 iff rs1 < rs2 (unsigned borrow). AND/OR/XOR clear C. Z = (result == 0) for opcodes 1–5.
- MOV, LDI, NOP and illegal leave Z and C unchanged.
- rf_wr_sel = 1 only in WB of LDI; otherwise 0.
- rd equal to rs1 and/or rs2 is legal: operands are captured in READ before the WB write, so there is no hazard.
- Outputs are held stable between updates. rf_wr_addr and rf_wr_data_imm are updated only on acceptance; rf_wr_data_alu is updated only in EXEC.

## Timing
- Acceptance is on the rising edge where instr_valid && instr_ready.
- ALU/MOV: READ, EXEC and WB occupy the 3 cycles after acceptance; instr_ready returns in the 4th cycle. Throughput is 1 instruction per 4 cycles.
- LDI/NOP/illegal: WB in the first cycle after acceptance; ready in the 2nd.
- The register-file write occurs on the clock edge that ends WB. An instruction accepted in IDLE right after WB reads the updated value.
- instr_valid held while instr_ready=0 is ignored; the instruction is not consumed.
- Reset values: state IDLE; rf_we, done, illegal, flag_z, flag_c, rf_wr_sel = 0; all addresses and data outputs = 0. instr_ready = 0 while rst is high, and 1 in the first cycle after rst falls.
- Reset mid-operation (any state): on the reset edge the block returns to IDLE and the in-flight instruction is discarded with no write. rf_we=0 in the following cycle, even if reset hit during WB.
- done and rf_we never assert in the same cycle as instr_ready.

## Test plan
- Reset, then LDI r1,0x7F → rf_we=1, rf_wr_sel=1, rf_wr_addr=1, rf_wr_data_imm=0x7F, done in cycle 1 after accept; ready next cycle.
- r1=0xFF, r2=0x01; ADD r3,r1,r2 → rf_wr_data_alu=0x00, Z=1, C=1, rf_we exactly 3 cycles after accept.
- r1=0x05, r2=0x07; SUB r4,r1,r2 → 0xFE, Z=0, C=1. Then XOR r4,r4,r4 → 0x00, Z=1, C=0.
- Opcode 0xA, then MOV r5,r3 → illegal+done pulse with rf_we=0 and flags unchanged; MOV writes r3's value to r5 and Z/C are unchanged.
- Assert rst during EXEC of ADD r6,r1,r2 → no rf_we, r6 keeps its old value, flags = 0, instr_ready=1 in the first cycle after rst drops.
- Back-to-back: hold instr_valid with LDI r0,0x10 then ADD r0,r0,r0 → second instruction accepted only when ready, and writes 0x20 to r0.

Source files
------------

// File: rtl/regfile_sequencer.sv
// regfile_sequencer: single-issue execute/writeback sequencer for an
// 8 x 8-bit register file. Accepts one 16-bit instruction per handshake,
// reads operands, runs the 8-bit ALU and issues the write-back.
module regfile_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [2:0]  rf_rd_addr1,
    output logic [2:0]  rf_rd_addr2,
    input  logic [7:0]  rf_rd_data1,
    input  logic [7:0]  rf_rd_data2,
    output logic        rf_we,
    output logic [2:0]  rf_wr_addr,
    output logic [7:0]  rf_wr_data_alu,
    output logic [7:0]  rf_wr_data_imm,
    output logic        rf_wr_sel,
    output logic        done,
    output logic        illegal,
    output logic        flag_z,
    output logic        flag_c
);

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_LDI = 4'd6;
    localparam logic [3:0] OP_MOV = 4'd7;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_op;
    logic [2:0]  r_rs1;
    logic [2:0]  r_rs2;
    logic [2:0]  r_rd;
    logic [7:0]  r_imm;
    logic [7:0]  r_opa;
    logic [7:0]  r_opb;
    logic [7:0]  r_alu;
    logic        r_z;
    logic        r_c;
    logic        w_accept;
    logic        w_needs_read;
    logic [7:0]  w_res;
    logic        w_c;
    logic        w_flag_upd;

    assign rf_rd_addr1    = r_rs1;
    assign rf_rd_addr2    = r_rs2;
    assign rf_wr_addr     = r_rd;
    assign rf_wr_data_imm = r_imm;
    assign rf_wr_data_alu = r_alu;
    assign flag_z         = r_z;
    assign flag_c         = r_c;

    // ALU ops and MOV need register operands; LDI/NOP/illegal go straight to WB
    assign w_needs_read = (instr[15:12] >= OP_ADD) && (instr[15:12] <= OP_MOV)
                          && (instr[15:12] != OP_LDI);

    // Next-state and handshake/write-back control decode
    always_comb begin
        w_next      = r_state;
        instr_ready = 1'b0;
        rf_we       = 1'b0;
        rf_wr_sel   = 1'b0;
        done        = 1'b0;
        illegal     = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                instr_ready = !rst;
                w_accept    = instr_valid && !rst;
                if (w_accept) begin
                    w_next = w_needs_read ? S_READ : S_WB;
                end
            end
            S_READ: w_next = S_EXEC;
            S_EXEC: w_next = S_WB;
            S_WB: begin
                done      = 1'b1;
                illegal   = r_op[3];
                rf_we     = !r_op[3] && (r_op != OP_NOP);
                rf_wr_sel = (r_op == OP_LDI);
                w_next    = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // ALU datapath on the captured operands
    always_comb begin
        w_res      = 8'd0;
        w_c        = 1'b0;
        w_flag_upd = 1'b1;
        case (r_op)
            OP_ADD:  {w_c, w_res} = {1'b0, r_opa} + {1'b0, r_opb};
            OP_SUB: begin
                w_res = r_opa - r_opb;
                w_c   = (r_opa < r_opb);
            end
            OP_AND:  w_res = r_opa & r_opb;
            OP_OR:   w_res = r_opa | r_opb;
            OP_XOR:  w_res = r_opa ^ r_opb;
            OP_MOV: begin
                w_res      = r_opa;
                w_flag_upd = 1'b0;
            end
            default: w_flag_upd = 1'b0;
        endcase
    end

    // State, instruction latch, operand capture and ALU/flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_op    <= 4'd0;
            r_rs1   <= 3'd0;
            r_rs2   <= 3'd0;
            r_rd    <= 3'd0;
            r_imm   <= 8'd0;
            r_opa   <= 8'd0;
            r_opb   <= 8'd0;
            r_alu   <= 8'd0;
            r_z     <= 1'b0;
            r_c     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op  <= instr[15:12];
                r_rd  <= instr[11:9];
                r_rs1 <= instr[8:6];
                r_rs2 <= instr[5:3];
                r_imm <= instr[7:0];
            end
            if (r_state == S_READ) begin
                r_opa <= rf_rd_data1;
                r_opb <= rf_rd_data2;
            end
            if (r_state == S_EXEC) begin
                r_alu <= w_res;
                if (w_flag_upd) begin
                    r_z <= (w_res == 8'd0);
                    r_c <= w_c;
                end
            end
        end
    end

endmodule
